nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/adder_ctrl_pkg.sv | 17 +
 rtl/nibble_add4.sv | 14 +
 rtl/nibble_serial_adder_ctrl.sv | 130 +++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and helpers for the nibble-serial adder sequencer.
package adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index register; a single-nibble adder still needs one bit.
    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// Purely combinational 4-bit add with carry-in, giving {carry, sum}.
module nibble_add4
    import adder_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{NIBBLE_W{1'b0}}, i_cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-nibble adder that reuses one 4-bit adder across cycles, LS nibble first,
// with valid/ready handshakes on operand and result sides.
module nibble_serial_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                        in_cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_cout,
    output logic                        busy
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_cout;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;

    logic [NIBBLE_W-1:0] w_a_nibs [NIBBLES];
    logic [NIBBLE_W-1:0] w_b_nibs [NIBBLES];
    logic [NIBBLE_W-1:0] w_nib_sum;
    logic                w_nib_cout;
    logic                w_accept;
    logic                w_last;
    logic                w_handshake;

    assign w_accept    = in_valid && r_in_ready;
    assign w_last      = (r_idx == IDX_LAST);
    assign w_handshake = r_out_valid && out_ready;

    // Split the captured operands into nibbles so the adder input is a plain idx-selected mux.
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nibs
        assign w_a_nibs[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
        assign w_b_nibs[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
    end

    nibble_add4 u_add (
        .i_a    (w_a_nibs[r_idx]),
        .i_b    (w_b_nibs[r_idx]),
        .i_cin  (r_carry),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state: accept -> NIBBLES add edges -> hold result until taken.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)    w_next_state = ADD;
            ADD:     if (w_last)      w_next_state = DONE;
            DONE:    if (w_handshake) w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // Handshake flags, operand capture, carry chain and nibble index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
        end else begin
            // Ready exactly while idle next cycle, so it never overlaps out_valid.
            r_in_ready <= (w_next_state == IDLE);
            if (r_state == IDLE && w_accept) begin
                r_a     <= in_a;
                r_b     <= in_b;
                r_carry <= in_cin;
                r_idx   <= '0;
            end
            if (r_state == ADD) begin
                r_carry <= w_nib_cout;
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                if (w_last) begin
                    r_cout      <= w_nib_cout;
                    r_out_valid <= 1'b1;
                end
            end
            if (r_state == DONE && w_handshake) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Sum register: only the nibble at idx is written during ADD; frozen in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (r_state == ADD) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (r_idx == IDX_W'(i)) r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_nib_sum;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl with NIBBLES=4.
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         busy;

    int n_total = 0;
    int n_bad   = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, expv);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with out_ready high: accept, latency, result, single-cycle valid.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 20) begin tick(); cnt++; end
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = a; in_b = b; in_cin = cin;
        tick();
        in_valid = 1'b0;
        in_a = 16'hDEAD; in_b = 16'hBEEF;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin tick(); cnt++; end
        chk({tag, "_lat"}, 32'(cnt), 32'(N));
        chk({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(out_cout), 32'(exp_cout));
        tick();
        chk({tag, "_vdrop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdyback"}, 32'(in_ready), 32'd1);
    endtask

    logic [W-1:0] ta [4] = '{16'hABCD, 16'h9999, 16'h0F0F, 16'h7FFF};
    logic [W-1:0] tb [4] = '{16'h1111, 16'h6667, 16'hF0F0, 16'h0001};
    logic         tc [4] = '{1'b0,     1'b0,     1'b1,     1'b0};
    logic [W-1:0] ts [4] = '{16'hBCDE, 16'h0000, 16'h0000, 16'h8000};
    logic         tco[4] = '{1'b0,     1'b1,     1'b1,     1'b0};

    initial begin
        int cyc, k, nres, last_acc, cnt;
        logic accepting;

        // Reset state.
        repeat (3) tick();
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_out_cout",  32'(out_cout),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_lo", 32'(in_ready), 32'd0);
        tick();
        chk("rel_ready_hi", 32'(in_ready), 32'd1);

        // Single operations from the test plan.
        run_op("op1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op("op2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        run_op("op3", 16'h0007, 16'h0003, 1'b1, 16'h000B, 1'b0);
        run_op("op4", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

        // Backpressure: result held for 5 cycles, new operands ignored.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 16'h0FF0; in_b = 16'h0110; in_cin = 1'b1;
        tick();
        in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin tick(); cnt++; end
        chk("bp_lat", 32'(cnt), 32'(N));
        for (int i = 0; i < 5; i++) begin
            in_a = 16'($urandom); in_b = 16'($urandom);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum",   32'(out_sum),   32'h1101);
            chk("bp_cout",  32'(out_cout),  32'd0);
            chk("bp_ready", 32'(in_ready),  32'd0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(out_valid), 32'd0);
        chk("bp_hs_ready", 32'(in_ready),  32'd1);

        // Back-to-back with in_valid and out_ready held high; operands scrambled when not accepted.
        cyc = 0; k = 0; nres = 0; last_acc = -1;
        while (nres < 4 && cyc < 200) begin
            accepting = in_ready && (k < 4);
            in_valid = (k < 4);
            if (accepting) begin
                in_a = ta[k]; in_b = tb[k]; in_cin = tc[k];
            end else begin
                in_a = 16'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
            end
            chk("b2b_excl", 32'(in_ready && out_valid), 32'd0);
            if (out_valid) begin
                chk("b2b_sum",  32'(out_sum),  32'(ts[nres]));
                chk("b2b_cout", 32'(out_cout), 32'(tco[nres]));
                nres++;
            end
            if (accepting) begin
                if (last_acc >= 0) chk("b2b_gap", 32'(cyc - last_acc), 32'(N + 2));
                last_acc = cyc;
                k++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("b2b_count", 32'(nres), 32'd4);

        // Reset after two ADD edges aborts the operation.
        cnt = 0;
        while (!in_ready && cnt < 20) begin tick(); cnt++; end
        in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("ab_in_ready",  32'(in_ready),  32'd0);
        chk("ab_out_valid", 32'(out_valid), 32'd0);
        chk("ab_out_sum",   32'(out_sum),   32'd0);
        chk("ab_out_cout",  32'(out_cout),  32'd0);
        chk("ab_busy",      32'(busy),      32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ab_rel_lo", 32'(in_ready), 32'd0);
        tick();
        chk("ab_rel_hi",    32'(in_ready),  32'd1);
        chk("ab_no_stale",  32'(out_valid), 32'd0);
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
